adder_seq_arb: RTL and testbench

Nibble-serial 16-bit add/subtract engine that time-shares one 4-bit ripple adder (`adder_4b`) between two requesters. A round-robin arbiter grants one requester at a time. The operands are latched and pushed through the adder one nibble per cycle, with carry chained between nibbles in a register. The block sits between client datapaths and the shared adder, and returns the 16-bit result, carry and signed overflow with a done pulse.

---
 rtl/adder_seq_arb.sv | 167 ++++++++++++++++
 tb/tb_adder_seq_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_arb.sv
// Nibble-serial 16-bit add/subtract engine sharing one 4-bit adder between two round-robin requesters.
// Optional feature macro: ADDER_SEQ_SUB_EN (defined = honour sub0/sub1, undefined = add only).
module adder_seq_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        sub0,
    input  logic        sub1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [15:0] sum,
    output logic        cout,
    output logic        of
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        w_grant;
    logic        w_win;

    logic [1:0]  r_idx;
    logic        r_c;
    logic        r_last_id;
    logic        r_owner;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_w;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done;
    logic        r_done_id;
    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_of;

    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic        w_sub_l;
    logic        w_cin;
    logic [3:0]  w_lo;
    logic [1:0]  w_hi;
    logic [3:0]  w_s;
    logic        w_co;
    logic        w_of;

    // Contention goes to the requester that did not win last time.
    assign w_win = (req0 && req1) ? ~r_last_id : req1;

`ifdef ADDER_SEQ_SUB_EN
    logic        r_sub;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (w_grant) begin
            r_sub <= w_win ? sub1 : sub0;
        end
    end

    assign w_sub_l = r_sub;
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_sub}};
`else
    logic        w_unused_sub;

    assign w_unused_sub = sub0 ^ sub1;
    assign w_sub_l      = 1'b0;
    assign w_b_nib      = r_b[{r_idx, 2'b00} +: 4];
`endif

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_cin   = (r_idx == 2'd0) ? w_sub_l : r_c;

    // Shared 4-bit ripple adder; split at bit 3 to expose the carry into the MSB.
    assign w_lo = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, w_cin};
    assign w_hi = {1'b0, w_a_nib[3]} + {1'b0, w_b_nib[3]} + {1'b0, w_lo[3]};
    assign w_s  = {w_hi[0], w_lo[2:0]};
    assign w_co = w_hi[1];
    assign w_of = w_lo[3] ^ w_hi[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_grant   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (req0 || req1) begin
                    w_grant   = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun:   if (r_idx == 2'd3) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= 2'd0;
            r_c       <= 1'b0;
            r_last_id <= 1'b1;
            r_owner   <= 1'b0;
            r_a       <= 16'h0000;
            r_b       <= 16'h0000;
            r_w       <= 16'h0000;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_sum     <= 16'h0000;
            r_cout    <= 1'b0;
            r_of      <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;
            if (w_grant) begin
                r_gnt0    <= ~w_win;
                r_gnt1    <= w_win;
                r_last_id <= w_win;
                r_owner   <= w_win;
                r_a       <= w_win ? a1 : a0;
                r_b       <= w_win ? b1 : b0;
                r_idx     <= 2'd0;
            end
            if (r_state == StRun) begin
                r_w[{r_idx, 2'b00} +: 4] <= w_s;
                r_c                      <= w_co;
                r_idx                    <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_sum     <= {w_s, r_w[11:0]};
                    r_cout    <= w_co;
                    r_of      <= w_of;
                    r_done_id <= r_owner;
                    r_done    <= 1'b1;
                end
            end
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = (r_state != StIdle);
    assign done    = r_done;
    assign done_id = r_done_id;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign of      = r_of;

endmodule

// File: tb/tb_adder_seq_arb.sv
// Scoreboard bench for adder_seq_arb: stimulus pushes expected results, a monitor pops on done.
module tb_adder_seq_arb;

    logic        clk;
    logic        rst_n;
    logic        req0;
    logic        req1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        sub0;
    logic        sub1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [15:0] sum;
    logic        cout;
    logic        of;

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        cout;
        logic        of;
    } exp_t;

    exp_t q_exp[$];
    int   checks;
    int   errors;
    int   cyc;
    int   last_gnt_cyc;

    adder_seq_arb u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .sub0    (sub0),
        .sub1    (sub1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout),
        .of      (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (gnt0 && gnt1) chk("gnt_exclusive", 32'd1, 32'd0);
        if (gnt0 || gnt1) last_gnt_cyc = cyc;
        if (done) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_exp.pop_front();
                chk("done_id", {31'd0, done_id}, {31'd0, e.id});
                chk("sum", {16'd0, sum}, {16'd0, e.sum});
                chk("cout", {31'd0, cout}, {31'd0, e.cout});
                chk("of", {31'd0, of}, {31'd0, e.of});
                chk("latency", cyc - last_gnt_cyc, 32'd4);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic push(input logic id, input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.id   = id;
        e.sum  = s;
        e.cout = c;
        e.of   = o;
        q_exp.push_back(e);
    endtask

    task automatic wait_gnt(input logic id);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (id ? gnt1 : gnt0) seen = 1;
        end
        if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
        if (id) req1 = 1'b0;
        else req0 = 1'b0;
    endtask

    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] es, input logic ec, input logic eo,
                         input bit do_push);
        if (do_push) push(id, es, ec, eo);
        if (id) begin
            a1 = a; b1 = b; sub1 = s; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; sub0 = s; req0 = 1'b1;
        end
        wait_gnt(id);
    endtask

    task automatic drain;
        for (int i = 0; i < 50 && q_exp.size() != 0; i++) @(negedge clk);
        if (q_exp.size() != 0) chk("drain_timeout", q_exp.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sum"}, {16'd0, sum}, 32'd0);
        chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
        chk({tag, "_of"}, {31'd0, of}, 32'd0);
        chk({tag, "_done_id"}, {31'd0, done_id}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    endtask

    initial begin
        int t0;
        checks = 0; errors = 0; cyc = 0; last_gnt_cyc = 0;
        rst_n = 1'b0; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; sub0 = 0; sub1 = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        issue(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1);
        drain();
        issue(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        drain();
        issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        drain();

        // Arbitration after a fresh reset: requester 0 first, then 1, then 0 again.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 16'h0002, 1'b0, 1'b0);
        push(1'b1, 16'h0004, 1'b0, 1'b0);
        a0 = 16'd1; b0 = 16'd1; a1 = 16'd2; b1 = 16'd2;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(1'b0);
        chk("contend_no_gnt1", {31'd0, gnt1}, 32'd0);
        t0 = cyc;
        wait_gnt(1'b1);
        chk("gnt1_spacing", cyc - t0, 32'd6);
        drain();
        push(1'b0, 16'h0100, 1'b0, 1'b0);
        push(1'b1, 16'h0000, 1'b1, 1'b1);
        a0 = 16'h00F0; b0 = 16'h0010; a1 = 16'h8000; b1 = 16'h8000;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(1'b0);
        chk("alt_no_gnt1", {31'd0, gnt1}, 32'd0);
        wait_gnt(1'b1);
        drain();

`ifdef ADDER_SEQ_SUB_EN
        issue(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
`else
        issue(1'b1, 16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 1'b0, 1);
`endif
        drain();

        // Abort mid-operation at idx 2 with req1 held across reset.
        issue(1'b1, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        push(1'b1, 16'h0303, 1'b0, 1'b0);
        a1 = 16'h0101; b1 = 16'h0202; sub1 = 1'b0; req1 = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        rst_n = 1'b1;
        @(negedge clk);
        chk("regrant_gnt1", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        drain();

        // Result hold with toggling operands and no requests.
        for (int i = 0; i < 10; i++) begin
            a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
            sub0 = ~sub0; sub1 = ~sub1;
            @(negedge clk);
            chk("hold_busy", {31'd0, busy}, 32'd0);
        end
        chk("hold_sum", {16'd0, sum}, 32'h0303);
        chk("hold_cout", {31'd0, cout}, 32'd0);
        chk("hold_of", {31'd0, of}, 32'd0);
        chk("hold_done_id", {31'd0, done_id}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
